// File: rtl/rps_match_scorer_pkg.sv
// Shared rock-paper-scissors definitions: move encodings, scorer FSM states,
// counter width and a round well-formedness helper.
package rps_match_scorer_pkg;

    localparam int CNT_W = 3;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        MOVE_NONE     = 2'd0,
        MOVE_ROCK     = 2'd1,
        MOVE_PAPER    = 2'd2,
        MOVE_SCISSORS = 2'd3
    } move_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A judge result is usable only when exactly one outcome line is high.
    function automatic logic rps_one_hot3(input logic a, input logic b, input logic c);
        return (a ^ b ^ c) & ~(a & b & c);
    endfunction

endpackage

// File: rtl/rps_sat_counter.sv
// 3-bit saturating counter with synchronous clear and a flag that fires when
// the current increment lands exactly on LIMIT.
module rps_sat_counter
    import rps_match_scorer_pkg::*;
#(
    parameter int LIMIT = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output cnt_t o_count,
    output logic o_tc_hit
);

    localparam cnt_t LIM      = cnt_t'(LIMIT);
    localparam cnt_t LIM_LAST = cnt_t'(LIMIT - 1);

    cnt_t r_count;
    logic w_at_limit;

    assign w_at_limit = (r_count == LIM);
    assign o_count    = r_count;
    assign o_tc_hit   = i_inc && (r_count == LIM_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_at_limit) begin
            r_count <= r_count + cnt_t'(1);
        end
    end

endmodule

// File: rtl/rps_match_scorer.sv
// Rock-paper-scissors match scorer: tallies judged rounds, declares a winner
// at WIN_TARGET wins or a draw at TIE_LIMIT ties, and flags malformed rounds.
module rps_match_scorer
    import rps_match_scorer_pkg::*;
#(
    parameter int WIN_TARGET = 3,
    parameter int TIE_LIMIT  = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       round_valid,
    input  logic       p1wins,
    input  logic       p2wins,
    input  logic       tied,
    output logic [2:0] p1_score,
    output logic [2:0] p2_score,
    output logic [2:0] tie_count,
    output logic       match_active,
    output logic       match_done,
    output logic       p1_match,
    output logic       p2_match,
    output logic       draw_match,
    output logic       round_ack,
    output logic       protocol_err
);

    state_t r_state;
    logic   r_active;
    logic   r_done;
    logic   r_p1_match;
    logic   r_p2_match;
    logic   r_draw_match;
    logic   r_ack;
    logic   r_err;

    logic w_in_play;
    logic w_clr;
    logic w_take;
    logic w_well;
    logic w_good;
    logic w_p1_inc;
    logic w_p2_inc;
    logic w_tie_inc;
    logic w_p1_hit;
    logic w_p2_hit;
    logic w_tie_hit;

    assign w_in_play = (r_state == ST_PLAY);
    // Start only acts outside PLAY, and it wins over any coincident round.
    assign w_clr     = start && !w_in_play;
    assign w_take    = w_in_play && round_valid;
    assign w_well    = rps_one_hot3(p1wins, p2wins, tied);
    assign w_good    = w_take && w_well;
    assign w_p1_inc  = w_good && p1wins;
    assign w_p2_inc  = w_good && p2wins;
    assign w_tie_inc = w_good && tied;

    rps_sat_counter #(.LIMIT(WIN_TARGET)) u_p1_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_clr),
        .i_inc    (w_p1_inc),
        .o_count  (p1_score),
        .o_tc_hit (w_p1_hit)
    );

    rps_sat_counter #(.LIMIT(WIN_TARGET)) u_p2_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_clr),
        .i_inc    (w_p2_inc),
        .o_count  (p2_score),
        .o_tc_hit (w_p2_hit)
    );

    rps_sat_counter #(.LIMIT(TIE_LIMIT)) u_tie_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_clr),
        .i_inc    (w_tie_inc),
        .o_count  (tie_count),
        .o_tc_hit (w_tie_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_active     <= 1'b0;
            r_done       <= 1'b0;
            r_p1_match   <= 1'b0;
            r_p2_match   <= 1'b0;
            r_draw_match <= 1'b0;
            r_ack        <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_PLAY: begin
                    if (w_take && !w_well) begin
                        r_err <= 1'b1;
                    end else if (w_good) begin
                        r_ack <= 1'b1;
                        if (w_p1_hit || w_p2_hit || w_tie_hit) begin
                            r_state      <= ST_DONE;
                            r_active     <= 1'b0;
                            r_done       <= 1'b1;
                            r_p1_match   <= w_p1_hit;
                            r_p2_match   <= w_p2_hit;
                            r_draw_match <= w_tie_hit;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        r_state      <= ST_PLAY;
                        r_active     <= 1'b1;
                        r_done       <= 1'b0;
                        r_p1_match   <= 1'b0;
                        r_p2_match   <= 1'b0;
                        r_draw_match <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign match_active = r_active;
    assign match_done   = r_done;
    assign p1_match     = r_p1_match;
    assign p2_match     = r_p2_match;
    assign draw_match   = r_draw_match;
    assign round_ack    = r_ack;
    assign protocol_err = r_err;

endmodule

// File: doc/rps_match_scorer.md
RPS_MATCH_SCORER -- requirements
Module: rps_match_scorer

Interface
REQ-001 Parameter WIN_TARGET, default 3, round wins needed to take the match (legal 1..7).
REQ-002 Parameter TIE_LIMIT, default 7, number of tied rounds that ends the match as a draw (legal 1..7).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin a new match.
REQ-006 round_valid  input  1  one-cycle strobe; judge outputs are valid this cycle.
REQ-007 p1wins, p2wins, tied  input  1 each  round result from the upstream judge.
REQ-008 p1_score, p2_score  output  3 each  rounds won in the current match.
REQ-009 tie_count  output  3  tied rounds in the current match.
REQ-010 match_active  output  1  high while in PLAY.
REQ-011 match_done  output  1  high while in DONE.
REQ-012 p1_match, p2_match, draw_match  output  1 each  one-hot match verdict, valid while match_done is high.
REQ-013 round_ack  output  1  one-cycle pulse confirming an accepted round.
REQ-014 protocol_err  output  1  one-cycle pulse marking a rejected malformed round.

Function
REQ-015 FSM states SHALL be IDLE, PLAY and DONE; all outputs SHALL be registered.
REQ-016 In IDLE or DONE, start=1 SHALL clear scores, tie_count and the verdict, and move the FSM to PLAY on the next edge.
REQ-017 In PLAY, start SHALL be ignored.
REQ-018 round_valid SHALL be ignored outside PLAY: no ack, no error, no count change.
REQ-019 Simultaneous start and round_valid in IDLE/DONE: start SHALL take effect and the round SHALL be discarded.
REQ-020 A round is well-formed when exactly one of p1wins, p2wins, tied is high.
REQ-021 In PLAY, a well-formed round SHALL increment the matching counter and pulse round_ack on the following edge (latency 1).
REQ-022 In PLAY, a malformed round SHALL pulse protocol_err for one cycle and SHALL leave all counts and the state unchanged.
REQ-023 When an accepted round brings p1_score to WIN_TARGET, on that same edge the FSM SHALL enter DONE and p1_match SHALL be set; p2 likewise via p2_match.
REQ-024 When an accepted tie brings tie_count to TIE_LIMIT, on that same edge the FSM SHALL enter DONE and draw_match SHALL be set.
REQ-025 Counters SHALL never exceed their limit or wrap, because the match terminates at the limit.
REQ-026 DONE SHALL hold all scores and the verdict until start or reset.
REQ-027 match_active and match_done SHALL be mutually exclusive; both SHALL be low in IDLE.
REQ-028 round_ack and protocol_err SHALL never be high in the same cycle.

Reset
REQ-029 rst_n low SHALL immediately force IDLE and drive every output to 0, regardless of clk.
REQ-030 A reset during PLAY SHALL abandon the match with no verdict; a new start is required after release.
REQ-031 Reset release SHALL be usable synchronously to clk; the first start is accepted on the first rising edge with rst_n high.

Structure
REQ-032 The FSM state encodings and the score/tie counter width (3) SHALL reside in a shared rps package/include alongside the existing move encodings.
REQ-033 One sub-module, rps_sat_counter (3-bit, clear/increment, terminal-count flag), SHALL be instantiated three times; the FSM and verdict logic SHALL stay in the top module.

Verification
REQ-034 Reset, start, then p1wins rounds on cycles 1, 3, 5 -> p1_score counts 1, 2, 3; match_done and p1_match are high after the third round; round_ack pulses 3 times.
REQ-035 Alternating p1/p2 wins followed by two more p2 wins -> final score p1_score=2, p2_score=3 with p2_match=1; further round_valid strobes in DONE produce no ack and no change.
REQ-036 Seven consecutive tied rounds (defaults) -> tie_count=7 and draw_match=1; start then clears all counts to 0 and sets match_active.
REQ-037 In PLAY, round_valid with p1wins=p2wins=1 and, separately, with all three low -> protocol_err pulses each time; scores unchanged; no round_ack.
REQ-038 rst_n dropped mid-cycle during PLAY at score 2-1 -> all outputs are 0 before the next clk edge; round_valid after release is ignored until start.
REQ-039 start and round_valid asserted together in IDLE -> FSM enters PLAY with all scores 0 and no round_ack.
